ispy_dump_ctrl: RTL and testbench
=================================

Name: ispy_dump_ctrl

Overview:
- Downstream readout sequencer for the input spybuffer.
- On a freeze request it freezes the spybuffer and captures its write pointer and overflow flag.
- It then walks the RAM from the oldest to the newest stored word, absorbing the 1-cycle RAM read latency.
- Words are presented chronologically on a valid/ready stream to the VME/readout logic, with a last-word marker and completion flag.

Parameters:
- DATA_W, 21, spybuffer word width.
- ADDR_W, 10, spybuffer address width; depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- freeze_req  in  1  level request to freeze and dump the spybuffer.
- wr_addr  in  ADDR_W  spybuffer address output; while unfrozen this is the next write location.
- spy_of  in  1  spybuffer overflow flag (buffer has wrapped at least once).
- freeze  out  1  freeze to spybuffer; also the RAM read enable.
- addr_sel  out  1  selects rd_addr as the spybuffer address while frozen.
- rd_addr  out  ADDR_W  spybuffer read address.
- rd_data  in  DATA_W  spybuffer read data, valid 1 cycle after rd_addr.
- dout  out  DATA_W  dumped word.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  consumer accepts dout when valid & ready.
- dout_last  out  1  qualifies the final word of the dump.
- busy  out  1  high from FREEZE entry until return to IDLE.
- done  out  1  dump completed normally; held in DONE.
- word_count  out  ADDR_W+1  number of words the dump will deliver; latched at capture.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, including word_count and rd_addr.
  - The 2-entry output buffer is emptied.
  - Reset overrides every other event, including mid-dump.
- States: IDLE, CAPTURE, READ, DONE.
- IDLE:
  - freeze=0, addr_sel=0.
  - freeze_req=1 -> CAPTURE; freeze=1 and busy=1 from the next cycle.
- CAPTURE (exactly 1 cycle, freeze already high so no further writes occur):
  - If spy_of=1: start=wr_addr, count=2**ADDR_W.
  - If spy_of=0: start=0, count=wr_addr.
  - word_count<=count.
  - count=0 -> DONE, with no words and no dout_last.
  - Otherwise -> READ, with addr_sel=1.
- READ:
  - rd_addr starts at start and increments modulo 2**ADDR_W per issued read, wrapping 2**ADDR_W-1 -> 0.
  - A read is issued in a cycle only if (words buffered + reads in flight - words accepted this cycle) < 2.
  - The 2-entry buffer guarantees no word is lost or duplicated under any dout_ready pattern.
  - Exactly count reads are issued; no further address changes after the last one.
  - dout presents words in issue order.
  - dout_valid stays high until the word is accepted; dout is stable while valid & !ready.
  - dout_last=1 with the count-th word only.
  - Acceptance of the last word -> DONE on the next cycle.
  - Best case, with dout_ready held at 1: first dout_valid appears 2 cycles after READ entry, then 1 word per cycle.
- DONE:
  - done=1, freeze=1, addr_sel=0, dout_valid=0.
  - freeze_req=0 -> IDLE; freeze, busy and done are 0 on the next cycle.
- Abort: freeze_req=0 while in CAPTURE or READ:
  - Outstanding reads and buffered words are discarded.
  - Next cycle: IDLE, dout_valid=0, freeze=0, done=0.
  - A word accepted in the abort cycle itself counts as delivered.
- freeze_req=1 in DONE keeps the state in DONE; no re-dump occurs until freeze_req has been deasserted.
- word_count holds its value until the next CAPTURE or reset.

Test Plan:
- No wrap: spy_of=0, wr_addr=5, contents addr=data, ready=1 -> dout 0,1,2,3,4 on consecutive cycles; dout_last on 4; word_count=5; done=1.
- Wrap: spy_of=1, wr_addr=1020 -> 1024 words at addresses 1020..1023,0..1019; dout_last on 1019; rd_addr wraps cleanly.
- Backpressure: dout_ready random 30% high over the wrap case -> exact 1024-word sequence, no gaps or duplicates; dout stable while stalled.
- Empty: spy_of=0, wr_addr=0 -> CAPTURE then DONE; dout_valid never asserted; word_count=0.
- Abort: freeze_req dropped after 3 words accepted in the wrap case -> dout_valid=0 and freeze=0 next cycle; state IDLE; a new freeze_req restarts from CAPTURE.
- Reset mid-READ: reset_n=0 for one cycle -> all outputs 0 next cycle; freeze_req still high -> new CAPTURE and full dump from scratch.

Source files
------------

// File: rtl/ispy_dump_if.sv
// Spybuffer-side and readout-stream signals of the spybuffer dump sequencer.
// The master is the sequencer; the slave is the spybuffer plus readout consumer.
interface ispy_dump_if #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 10
);
  logic              freeze_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              spy_of;
  logic              freeze;
  logic              addr_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  freeze_req, wr_addr, spy_of, rd_data, dout_ready,
    output freeze, addr_sel, rd_addr, dout, dout_valid, dout_last,
           busy, done, word_count
  );

  modport slave (
    output freeze_req, wr_addr, spy_of, rd_data, dout_ready,
    input  freeze, addr_sel, rd_addr, dout, dout_valid, dout_last,
           busy, done, word_count
  );
endinterface

// File: rtl/ispy_dump_ctrl.sv
// Freezes the input spybuffer and streams its contents oldest-first,
// hiding the 1-cycle RAM read latency behind a 2-entry skid buffer.
module ispy_dump_ctrl #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  ispy_dump_if.master  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cap_count, reads_left, word_count_r;
  logic [ADDR_W-1:0] cap_start, rd_addr_r;
  logic              vld_p1, last_p1;
  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        buf_last;
  logic [1:0]        buf_cnt, occ;
  logic              head, tail;
  logic              dout_valid_i, accept, issue, flush;
  logic              freeze_i, addr_sel_i, busy_i, done_i;

  // A wrapped buffer holds a full depth starting at the write pointer.
  assign cap_count = bus.spy_of ? DEPTH : {1'b0, bus.wr_addr};
  assign cap_start = bus.spy_of ? bus.wr_addr : '0;

  assign dout_valid_i = (state == READ) && (buf_cnt != '0);
  assign accept       = dout_valid_i && bus.dout_ready;
  assign occ          = buf_cnt + {1'b0, vld_p1} - {1'b0, accept};
  assign issue        = (state == READ) && bus.freeze_req &&
                        (reads_left != '0) && (occ < 2'd2);
  assign flush        = (state_nxt != READ);

  always_comb begin
    state_nxt  = state;
    freeze_i   = 1'b0;
    addr_sel_i = 1'b0;
    busy_i     = 1'b0;
    done_i     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.freeze_req) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        freeze_i = 1'b1;
        busy_i   = 1'b1;
        if (!bus.freeze_req)      state_nxt = IDLE;
        else if (cap_count == '0) state_nxt = DONE;
        else                      state_nxt = READ;
      end
      READ: begin
        freeze_i   = 1'b1;
        addr_sel_i = 1'b1;
        busy_i     = 1'b1;
        if (!bus.freeze_req)                state_nxt = IDLE;
        else if (accept && buf_last[head])  state_nxt = DONE;
      end
      DONE: begin
        freeze_i = 1'b1;
        busy_i   = 1'b1;
        done_i   = 1'b1;
        if (!bus.freeze_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_addr_r    <= '0;
      reads_left   <= '0;
      word_count_r <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      buf_cnt      <= '0;
      buf_last     <= '0;
      head         <= 1'b0;
      tail         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CAPTURE) begin
        rd_addr_r    <= cap_start;
        reads_left   <= cap_count;
        word_count_r <= cap_count;
      end else if (issue) begin
        reads_left <= reads_left - CNT_W'(1);
        // Address parks on the final word instead of stepping past it.
        if (reads_left != CNT_W'(1)) rd_addr_r <= rd_addr_r + ADDR_W'(1);
      end
      // p0 -> p1: address issued to RAM; p1 -> buffer: read data lands.
      if (flush) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
        buf_cnt <= '0;
        head    <= 1'b0;
        tail    <= 1'b0;
      end else begin
        vld_p1  <= issue;
        last_p1 <= issue && (reads_left == CNT_W'(1));
        buf_cnt <= occ;
        if (accept) head <= ~head;
        if (vld_p1) begin
          tail           <= ~tail;
          buf_last[tail] <= last_p1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) buf_data[tail] <= bus.rd_data;
  end

  assign bus.freeze     = freeze_i;
  assign bus.addr_sel   = addr_sel_i;
  assign bus.busy       = busy_i;
  assign bus.done       = done_i;
  assign bus.rd_addr    = rd_addr_r;
  assign bus.word_count = word_count_r;
  assign bus.dout_valid = dout_valid_i;
  assign bus.dout       = dout_valid_i ? buf_data[head] : '0;
  assign bus.dout_last  = dout_valid_i && buf_last[head];

endmodule

// File: tb/tb_ispy_dump_ctrl.sv
// Scoreboard bench for the spybuffer dump sequencer with a registered-read RAM model.
module tb_ispy_dump_ctrl;
  localparam int DATA_W = 21;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ispy_dump_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ispy_dump_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_cnt = 0;
  bit   valid_seen = 1'b0;
  bit   chk_stable = 1'b1;
  bit   rand_rdy   = 1'b0;

  always @(posedge clk)
    if (bus.freeze) bus.rd_data <= mem[bus.addr_sel ? bus.rd_addr : bus.wr_addr];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic [DATA_W-1:0] prev_dout;
    bit prev_stall;
    exp_t e;
    prev_stall = 1'b0;
    prev_dout  = '0;
    forever begin
      @(negedge clk);
      if (bus.dout_valid) valid_seen = 1'b1;
      if (chk_stable && prev_stall) begin
        check("stall_valid", bus.dout_valid, 1);
        check("stall_data", bus.dout, prev_dout);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got word %0d expected none", bus.dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", bus.dout, e.data);
          check("dout_last", bus.dout_last, e.last);
        end
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.dout_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic fill(input logic [10:0] tag);
    for (int i = 0; i < DEPTH; i++) mem[i] = {tag, ADDR_W'(i)};
  endtask

  task automatic load_exp(input logic [10:0] tag, input int start, input int n);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      e.data = {tag, ADDR_W'((start + k) % DEPTH)};
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_freeze"}, bus.freeze, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_valid"}, bus.dout_valid, 0);
    check({name, "_dout"}, bus.dout, 0);
    check({name, "_last"}, bus.dout_last, 0);
    check({name, "_addr_sel"}, bus.addr_sel, 0);
    check({name, "_word_count"}, bus.word_count, 0);
    check({name, "_rd_addr"}, bus.rd_addr, 0);
  endtask

  // Freeze request is already high; waits for DONE then releases.
  task automatic finish_dump(input string name, input int n, input int start,
                             input int exp_cycles);
    int cyc;
    cyc = 0;
    while (!bus.done && cyc < 20000) begin
      tick();
      cyc++;
    end
    check({name, "_done"}, bus.done, 1);
    if (exp_cycles >= 0) check({name, "_cycles"}, cyc, exp_cycles);
    check({name, "_word_count"}, bus.word_count, n);
    check({name, "_sb_left"}, exp_q.size(), 0);
    check({name, "_done_valid"}, bus.dout_valid, 0);
    check({name, "_done_freeze"}, bus.freeze, 1);
    check({name, "_done_addr_sel"}, bus.addr_sel, 0);
    if (n > 0) check({name, "_last_addr"}, bus.rd_addr, (start + n - 1) % DEPTH);
    tick();
    check({name, "_hold_done"}, bus.done, 1);
    bus.freeze_req = 1'b0;
    tick();
    check({name, "_rel_freeze"}, bus.freeze, 0);
    check({name, "_rel_busy"}, bus.busy, 0);
    check({name, "_rel_done"}, bus.done, 0);
  endtask

  task automatic run_dump(input string name, input logic [10:0] tag, input bit of,
                          input int wa, input int exp_cycles);
    int n, start;
    n     = of ? DEPTH : wa;
    start = of ? wa : 0;
    fill(tag);
    load_exp(tag, start, n);
    bus.spy_of     = of;
    bus.wr_addr    = ADDR_W'(wa);
    bus.freeze_req = 1'b1;
    finish_dump(name, n, start, exp_cycles);
  endtask

  initial begin : stim
    int cyc;
    reset_n        = 1'b0;
    bus.freeze_req = 1'b0;
    bus.wr_addr    = '0;
    bus.spy_of     = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();

    run_dump("nowrap", 11'd1, 1'b0, 5, 9);
    run_dump("wrap", 11'd2, 1'b1, 1020, 1028);

    rand_rdy = 1'b1;
    run_dump("bp", 11'd3, 1'b1, 1020, -1);
    rand_rdy = 1'b0;
    bus.dout_ready = 1'b1;

    valid_seen = 1'b0;
    run_dump("empty", 11'd7, 1'b0, 0, 2);
    check("empty_valid_seen", valid_seen, 0);

    // Abort after three accepted words; the abort-cycle word still counts.
    fill(11'd4);
    load_exp(11'd4, 1020, DEPTH);
    bus.spy_of = 1'b1;
    bus.wr_addr = ADDR_W'(1020);
    acc_cnt = 0;
    bus.freeze_req = 1'b1;
    cyc = 0;
    while (acc_cnt < 3 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("abort_acc3", acc_cnt, 3);
    bus.freeze_req = 1'b0;
    tick();
    check("abort_valid", bus.dout_valid, 0);
    check("abort_freeze", bus.freeze, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_acc4", acc_cnt, 4);
    exp_q.delete();
    run_dump("restart", 11'd5, 1'b0, 3, 7);

    // Reset in the middle of a wrapped dump, freeze request held throughout.
    fill(11'd6);
    load_exp(11'd6, 1020, DEPTH);
    bus.spy_of = 1'b1;
    bus.wr_addr = ADDR_W'(1020);
    acc_cnt = 0;
    bus.freeze_req = 1'b1;
    cyc = 0;
    while (acc_cnt < 10 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("rst_mid_acc", acc_cnt, 10);
    chk_stable = 1'b0;
    bus.dout_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    check_idle_zero("rst_mid");
    reset_n = 1'b1;
    bus.dout_ready = 1'b1;
    load_exp(11'd6, 1020, DEPTH);
    tick();
    chk_stable = 1'b1;
    check("rst_capture_busy", bus.busy, 1);
    finish_dump("rst_redump", DEPTH, 1020, 1027);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
